// File: rtl/udma_event_collector.sv
`default_nettype none
// ============================================================================
//  Module   : udma_event_collector
//  Purpose  : Collects single-cycle uDMA event pulses into one pending bit per
//             event, arbitrates them round-robin, and streams the granted
//             event IDs through a small output FIFO.
//  Ports    : sys_clk_i    - clock, all state on the rising edge
//             sys_rst_ni   - asynchronous active-low reset
//             events_i     - [N_PERIPH][4] event pulses, ID = periph*4 + evt
//             clr_lost_i   - synchronous clear of the lost indication
//             evt_valid_o  - stream valid (FIFO not empty)
//             evt_data_o   - stream data (event ID, FIFO head)
//             evt_ready_i  - stream ready
//             lost_o       - sticky "an event pulse was dropped" flag
//             lost_cnt_o   - saturating count of cycles with a loss
//                            (only with UDMA_EVT_LOST_CNT_EN defined)
//  Macro    : UDMA_EVT_LOST_CNT_EN - adds lost_cnt_o and its counter
//  Revision : 1.0 - initial release
// ============================================================================
module udma_event_collector #(
  parameter int N_PERIPH   = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     sys_clk_i,
  input  logic                     sys_rst_ni,
  input  logic [N_PERIPH-1:0][3:0] events_i,
  input  logic                     clr_lost_i,
  output logic                     evt_valid_o,
  output logic [7:0]               evt_data_o,
  input  logic                     evt_ready_i,
`ifdef UDMA_EVT_LOST_CNT_EN
  output logic [15:0]              lost_cnt_o,
`endif
  output logic                     lost_o
);

  localparam int         N_EVT    = 4 * N_PERIPH;
  localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         PW       = AW + 1;
  localparam logic [7:0] LAST_RST = 8'(N_EVT - 1);

  logic [N_EVT-1:0] events_flat;
  logic [N_EVT-1:0] pending_q, pending_d;
  logic [7:0]       last_grant_q, last_grant_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             lost_q, lost_d;
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];

  logic [N_EVT-1:0] mask_hi;
  logic [N_EVT-1:0] grant_oh;
  logic [N_EVT-1:0] loss_vec;
  logic [7:0]       hi_idx, lo_idx, grant_idx;
  logic             any_pending, any_hi, any_loss;
  logic             fifo_full, fifo_empty, pop, grant_en;

  assign events_flat = events_i;

  // Round-robin search: first pending bit strictly above last_grant, else
  // the lowest pending bit overall (the wrap from N_EVT-1 back to 0).
  always_comb begin
    mask_hi = '0;
    for (int k = 0; k < N_EVT; k++) begin
      mask_hi[k] = pending_q[k] && (8'(k) > last_grant_q);
    end
  end

  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int k = N_EVT - 1; k >= 0; k--) begin
      if (mask_hi[k])   hi_idx = 8'(k);
      if (pending_q[k]) lo_idx = 8'(k);
    end
  end

  assign any_pending = |pending_q;
  assign any_hi      = |mask_hi;
  assign grant_idx   = any_hi ? hi_idx : lo_idx;

  // Extra pointer bit tells full from empty when the addresses coincide.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && evt_ready_i;
  // A pop in the same cycle frees the slot the push needs.
  assign grant_en   = any_pending && (!fifo_full || pop);

  always_comb begin
    grant_oh = '0;
    for (int k = 0; k < N_EVT; k++) begin
      grant_oh[k] = grant_en && (grant_idx == 8'(k));
    end
  end

  // A pulse only counts as lost if its bit is already pending and is not
  // leaving in this cycle; a pulse on the granted bit simply re-arms it.
  assign loss_vec = events_flat & pending_q & ~grant_oh;
  assign any_loss = |loss_vec;

  always_comb begin
    pending_d    = (pending_q & ~grant_oh) | events_flat;
    last_grant_d = grant_en ? grant_idx : last_grant_q;
    wr_ptr_d     = grant_en ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d     = pop      ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    lost_d       = lost_q;
    if (clr_lost_i) lost_d = 1'b0;
    if (any_loss)   lost_d = 1'b1;
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      pending_q    <= '0;
      last_grant_q <= LAST_RST;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      lost_q       <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      lost_q       <= lost_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge sys_clk_i) begin
    if (grant_en) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= grant_idx;
    end
  end

  assign evt_valid_o = !fifo_empty;
  assign evt_data_o  = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign lost_o      = lost_q;

`ifdef UDMA_EVT_LOST_CNT_EN
  logic [15:0] lost_cnt_q, lost_cnt_d;

  // An increment coinciding with a clear restarts the count at 1.
  always_comb begin
    lost_cnt_d = lost_cnt_q;
    if (any_loss) begin
      if (clr_lost_i)                 lost_cnt_d = 16'd1;
      else if (lost_cnt_q != 16'hFFFF) lost_cnt_d = lost_cnt_q + 16'd1;
    end else if (clr_lost_i) begin
      lost_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) lost_cnt_q <= 16'd0;
    else             lost_cnt_q <= lost_cnt_d;
  end

  assign lost_cnt_o = lost_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udma_event_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_udma_event_collector
//  Purpose  : Directed self-checking bench for udma_event_collector with the
//             default parameters (32 peripherals, 8-entry FIFO).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_udma_event_collector;

  logic         clk;
  logic         rst_n;
  logic [127:0] ev;
  logic         clr;
  logic         ready;
  logic         valid;
  logic [7:0]   data;
  logic         lost;
`ifdef UDMA_EVT_LOST_CNT_EN
  logic [15:0]  lost_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  udma_event_collector #(
    .N_PERIPH  (32),
    .FIFO_DEPTH(8)
  ) dut (
    .sys_clk_i  (clk),
    .sys_rst_ni (rst_n),
    .events_i   (ev),
    .clr_lost_i (clr),
    .evt_valid_o(valid),
    .evt_data_o (data),
    .evt_ready_i(ready),
`ifdef UDMA_EVT_LOST_CNT_EN
    .lost_cnt_o (lost_cnt),
`endif
    .lost_o     (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] bitv(input int k);
    logic [127:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Drive a vector of pulses for exactly one cycle.
  task automatic pulse(input logic [127:0] v);
    ev = v;
    step();
    ev = '0;
  endtask

  task automatic do_reset();
    ev    = '0;
    clr   = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  int ord29 [12] = '{100, 5, 50, 7, 60, 20, 90, 1, 40, 2, 120, 30};
  int exp29 [12] = '{100, 5, 50, 7, 60, 20, 90, 1, 2, 30, 40, 120};

  initial begin
    rst_n = 1'b0;
    ev    = '0;
    clr   = 1'b0;
    ready = 1'b0;
    #2;
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_data",  {24'd0, data},  32'd0);
    check("rst_lost",  {31'd0, lost},  32'd0);
`ifdef UDMA_EVT_LOST_CNT_EN
    check("rst_cnt",   {16'd0, lost_cnt}, 32'd0);
`endif
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single pulse on events_i[5][2] -> ID 22, two cycles later, one beat.
    ready = 1'b1;
    pulse(bitv(5 * 4 + 2));
    check("t1_lat1_valid", {31'd0, valid}, 32'd0);
    step();
    check("t1_valid", {31'd0, valid}, 32'd1);
    check("t1_data",  {24'd0, data},  32'd22);
    step();
    check("t1_one_beat", {31'd0, valid}, 32'd0);

    // Three simultaneous pulses, then a wrap to index 0.
    do_reset();
    ready = 1'b1;
    pulse(bitv(3) | bitv(64) | bitv(127));
    check("t2_lat1_valid", {31'd0, valid}, 32'd0);
    step();
    check("t2_v0", {31'd0, valid}, 32'd1);
    check("t2_d0", {24'd0, data},  32'd3);
    step();
    check("t2_v1", {31'd0, valid}, 32'd1);
    check("t2_d1", {24'd0, data},  32'd64);
    step();
    check("t2_v2", {31'd0, valid}, 32'd1);
    check("t2_d2", {24'd0, data},  32'd127);
    step();
    check("t2_drained", {31'd0, valid}, 32'd0);
    pulse(bitv(0));
    step();
    check("t2_wrap_v", {31'd0, valid}, 32'd1);
    check("t2_wrap_d", {24'd0, data},  32'd0);
    step();
    check("t2_wrap_end", {31'd0, valid}, 32'd0);

    // Twelve distinct pulses into an 8-deep FIFO with ready low.
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 12; i++) pulse(bitv(ord29[i]));
    check("t3_hold_v", {31'd0, valid}, 32'd1);
    check("t3_hold_d", {24'd0, data},  32'd100);
    step();
    check("t3_stable_v", {31'd0, valid}, 32'd1);
    check("t3_stable_d", {24'd0, data},  32'd100);
    check("t3_nolost_full", {31'd0, lost}, 32'd0);
    ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t3_v%0d", i), {31'd0, valid}, 32'd1);
      check($sformatf("t3_d%0d", i), {24'd0, data},  32'(exp29[i]));
      step();
    end
    check("t3_drained", {31'd0, valid}, 32'd0);
    check("t3_lost",    {31'd0, lost},  32'd0);

    // Losses on index 9 while it is stuck pending behind a full FIFO.
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 8; i++) pulse(bitv(i));
    pulse(bitv(9));
    check("t4_pend_nolost", {31'd0, lost}, 32'd0);
    pulse(bitv(9));
    check("t4_lost1", {31'd0, lost}, 32'd1);
    pulse(bitv(9));
    check("t4_lost2", {31'd0, lost}, 32'd1);
`ifdef UDMA_EVT_LOST_CNT_EN
    check("t4_cnt2", {16'd0, lost_cnt}, 32'd2);
`endif
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t4_clr_lost", {31'd0, lost}, 32'd0);
`ifdef UDMA_EVT_LOST_CNT_EN
    check("t4_clr_cnt", {16'd0, lost_cnt}, 32'd0);
`endif
    check("t4_head", {24'd0, data}, 32'd0);
    // Loss coinciding with a clear: the loss wins.
    ev  = bitv(9);
    clr = 1'b1;
    step();
    ev  = '0;
    clr = 1'b0;
    check("t4_clr_vs_loss", {31'd0, lost}, 32'd1);
`ifdef UDMA_EVT_LOST_CNT_EN
    check("t4_clr_vs_cnt", {16'd0, lost_cnt}, 32'd1);
`endif
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t4_clr2", {31'd0, lost}, 32'd0);

    // Pulse on index 9 during its own grant cycle -> emitted twice.
    do_reset();
    ready = 1'b1;
    ev = bitv(9);
    step();
    ev = bitv(9);
    step();
    ev = '0;
    check("t5_v0", {31'd0, valid}, 32'd1);
    check("t5_d0", {24'd0, data},  32'd9);
    step();
    check("t5_v1", {31'd0, valid}, 32'd1);
    check("t5_d1", {24'd0, data},  32'd9);
    step();
    check("t5_end",  {31'd0, valid}, 32'd0);
    check("t5_lost", {31'd0, lost},  32'd0);

    // Reset with 4 queued and 3 pending events discards everything.
    do_reset();
    ready = 1'b0;
    pulse(bitv(10) | bitv(11) | bitv(12) | bitv(13) | bitv(14) | bitv(15) | bitv(16));
    step();
    step();
    step();
    step();
    check("t6_pre_v", {31'd0, valid}, 32'd1);
    check("t6_pre_d", {24'd0, data},  32'd10);
    rst_n = 1'b0;
    #1;
    check("t6_rst_v", {31'd0, valid}, 32'd0);
    check("t6_rst_d", {24'd0, data},  32'd0);
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("t6_quiet%0d", i), {31'd0, valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/udma_event_collector.md
UDMA_EVENT_COLLECTOR -- requirements
Module: udma_event_collector

Interface
REQ-001 SHALL have parameter N_PERIPH, default 32, number of uDMA peripheral event groups, each 4 events wide (range 1..64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, output FIFO entries (power of two, 2..32).
REQ-003 SHALL have port sys_clk_i, input, 1 bit: the only clock; all state on rising edge.
REQ-004 SHALL have port sys_rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port events_i, input, [N_PERIPH-1:0][3:0]: single-cycle event pulses from the uDMA subsystem; flat index = periph*4 + evt.
REQ-006 SHALL have port clr_lost_i, input, 1 bit: synchronous clear of the lost-event indication.
REQ-007 SHALL have port evt_valid_o, output, 1 bit: stream valid.
REQ-008 SHALL have port evt_data_o, output, 8 bits: event ID, equal to the flat index zero-extended to 8 bits.
REQ-009 SHALL have port evt_ready_i, input, 1 bit: stream ready from the SoC event unit.
REQ-010 SHALL have port lost_o, output, 1 bit: sticky flag, set when an event pulse is dropped.

Function
REQ-011 SHALL hold one pending bit per flat index (4*N_PERIPH bits); a pulse on events_i[k] in cycle N sets pending[k] at edge N+1.
REQ-012 SHALL arbitrate pending bits round-robin: start at last_grant+1, wrap from 4*N_PERIPH-1 to 0, and select the first set bit.
REQ-013 SHALL grant at most one index per cycle, and only when the FIFO is not full or a pop occurs in the same cycle.
REQ-014 SHALL, on grant of index g, push g into the FIFO, clear pending[g], and set last_grant to g at the same edge.
REQ-015 SHALL give priority to set when a new pulse on index g coincides with the grant of g: pending[g] stays 1, nothing is lost, and g is emitted twice.
REQ-016 SHALL count an event as lost when events_i[k] pulses while pending[k] is already 1 and is not being granted in that cycle; a lost event sets lost_o at the next edge.
REQ-017 SHALL clear lost_o on clr_lost_i; if a loss occurs in the same cycle as the clear, the loss wins and lost_o stays 1.
REQ-018 SHALL drive evt_valid_o equal to FIFO not empty, and evt_data_o equal to the FIFO head; evt_data_o SHALL be stable while evt_valid_o=1 and evt_ready_i=0.
REQ-019 SHALL pop the FIFO on evt_valid_o & evt_ready_i; a simultaneous push and pop when full SHALL keep the occupancy at FIFO_DEPTH.
REQ-020 SHALL preserve grant order in the FIFO; pointers SHALL wrap modulo FIFO_DEPTH, with full and empty distinguished by an extra pointer bit.
REQ-021 SHALL have minimum latency of 2 cycles: pulse in cycle N, pending at N+1, grant/push at N+1, evt_valid_o=1 in cycle N+2.
REQ-022 SHALL, while the FIFO is full and no pop occurs, keep all pending bits set and make no grant; accumulation continues per REQ-011 and REQ-016.

Reset
REQ-023 SHALL, on sys_rst_ni=0, asynchronously clear pending, FIFO pointers and lost_o, and set last_grant to 4*N_PERIPH-1 so the first search starts at index 0.
REQ-024 SHALL, while in reset, drive evt_valid_o=0, evt_data_o=0 and lost_o=0; reset mid-transfer SHALL discard all queued and pending events.

Configuration
REQ-025 SHALL gate the lost counter with macro UDMA_EVT_LOST_CNT_EN; when defined, add output lost_cnt_o, 16 bits, reset 0. It increments by 1 in each cycle with at least one lost event, saturates at 16'hFFFF, and clears on clr_lost_i (an increment in the same cycle wins, giving 1).
REQ-026 SHALL, when UDMA_EVT_LOST_CNT_EN is undefined, have no lost_cnt_o port and no counter logic; all other behaviour is identical.

Verification
REQ-027 SHALL cover: single pulse on events_i[5][2] with evt_ready_i=1 -> evt_data_o=8'd22 valid exactly 2 cycles later, one beat.
REQ-028 SHALL cover: pulses on indices 3, 64 and 127 in the same cycle, ready=1 -> output order 3, 64, 127 on consecutive cycles; then a pulse on index 0 -> 0 is emitted next (wrap).
REQ-029 SHALL cover: ready=0, 12 distinct single pulses with FIFO_DEPTH=8 -> evt_valid_o held and head stable; after ready=1, all 12 IDs are emitted in round-robin order and lost_o=0.
REQ-030 SHALL cover: two pulses on index 9 while index 9 is pending and ready=0 -> lost_o=1 (lost_cnt_o=2 if the macro is enabled); clr_lost_i -> both return to 0.
REQ-031 SHALL cover: a pulse on index 9 in its grant cycle -> 9 is emitted twice and lost_o stays 0.
REQ-032 SHALL cover: sys_rst_ni asserted with 4 queued and 3 pending events -> evt_valid_o=0 immediately; after release, no events are emitted.
